// File: rtl/multicycle_control_unit.sv
// ---------------------------------------------------------------------------
// multicycle_control_unit
//
// Purpose:
//   Control FSM for a multi-cycle RV32I core built around one shared memory
//   and the IR / OldPC / A / B / ALUOut datapath registers. Each instruction
//   is sequenced over several states. Memory accesses use a ready strobe
//   (MemReady). A watchdog traps if memory never answers. Unsupported
//   opcodes, and unsupported funct3 values, lead to a sticky TRAP state.
//
// Parameters:
//   ALU_CTRL_W   width of ALUControl (>= 3); the extra MSBs are always 0
//   MEM_TIMEOUT  max memory wait cycles before trapping; 0 disables the watchdog
//
// Ports:
//   CLK         in   clock, rising edge
//   RESET       in   asynchronous reset, active low
//   EN          in   1 = advance, 0 = stall (state and counter frozen)
//   OP          in   instr[6:0]
//   funct3      in   instr[14:12]
//   funct7b5    in   instr[30]
//   Zero        in   ALU zero flag
//   MemReady    in   memory completes the current access this cycle
//   PCWrite     out  PC load enable
//   AdrSrc      out  memory address select (0 PC, 1 ALUOut)
//   MemRead     out  memory read request
//   MemWrite    out  memory write request
//   IRWrite     out  IR / OldPC load enable
//   RegWrite    out  register-file write enable
//   ResultSrc   out  00 ALUOut, 01 Data, 10 ALUResult
//   ALUSrcA     out  00 PC, 01 OldPC, 10 A
//   ALUSrcB     out  00 B, 01 ImmExt, 10 constant 4
//   ImmSrc      out  immediate format, decoded from OP
//   ALUControl  out  000 add, 001 sub, 010 and, 011 or, 101 slt
//   Trap        out  sticky trap flag, cleared only by reset
//
// Configuration macro:
//   MCCU_BRANCH_EXT_EN  when defined, bne (funct3=001) is accepted as well as
//                       beq. Otherwise only beq is legal.
// ---------------------------------------------------------------------------
module multicycle_control_unit #(
    parameter int ALU_CTRL_W  = 3,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  EN,
    input  logic [6:0]            OP,
    input  logic [2:0]            funct3,
    input  logic                  funct7b5,
    input  logic                  Zero,
    input  logic                  MemReady,
    output logic                  PCWrite,
    output logic                  AdrSrc,
    output logic                  MemRead,
    output logic                  MemWrite,
    output logic                  IRWrite,
    output logic                  RegWrite,
    output logic [1:0]            ResultSrc,
    output logic [1:0]            ALUSrcA,
    output logic [1:0]            ALUSrcB,
    output logic [1:0]            ImmSrc,
    output logic [ALU_CTRL_W-1:0] ALUControl,
    output logic                  Trap
);

    // Opcodes understood by the sequencer
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // ALU operation codes
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Multiplexer select encodings
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_REG   = 2'b10;
    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    // The watchdog counter only needs to reach MEM_TIMEOUT-1. On the next
    // waiting cycle it would hit MEM_TIMEOUT, so the FSM traps on that
    // edge instead.
    localparam int              CNT_W    = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic            WD_ON    = (MEM_TIMEOUT > 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_TRAP
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] wait_cnt;
    logic             mem_wait;
    logic             wd_expire;
    logic             enable_ok;
    logic             alu_f3_legal;
    logic             branch_legal;
    logic             branch_taken;
    logic             pc_write_raw;
    logic             mem_read_raw;
    logic             mem_write_raw;
    logic             ir_write_raw;
    logic             reg_write_raw;
    logic [2:0]       alu_op;

    // Enables are suppressed during a stall and while reset is held. This
    // is a combinational gate, so a stall or a reset cancels a strobe
    // within the same cycle.
    assign enable_ok = EN & RESET;

    assign wd_expire = WD_ON && (wait_cnt == CNT_LAST);

    // ALU-class instructions support only add/sub, slt, or and and.
    always_comb begin
        alu_f3_legal = 1'b0;
        case (funct3)
            3'b000, 3'b010, 3'b110, 3'b111: alu_f3_legal = 1'b1;
            default:                        alu_f3_legal = 1'b0;
        endcase
    end

    // Branch flavours. The optional bne support reuses the subtractor's zero
    // flag, inverted, and funct3[0] selects the sense.
`ifdef MCCU_BRANCH_EXT_EN
    assign branch_legal = (funct3 == 3'b000) || (funct3 == 3'b001);
    assign branch_taken = funct3[0] ? ~Zero : Zero;
`else
    assign branch_legal = (funct3 == 3'b000);
    assign branch_taken = Zero;
`endif

    // The immediate format follows OP directly. The datapath needs it
    // before the FSM reaches the state that uses it.
    always_comb begin
        ImmSrc = 2'b00;
        case (OP)
            OP_STORE:  ImmSrc = 2'b01;
            OP_BRANCH: ImmSrc = 2'b10;
            OP_JAL:    ImmSrc = 2'b11;
            default:   ImmSrc = 2'b00;
        endcase
    end

    // State register. It advances only when EN is high. An asserted reset
    // sends it back to FETCH and abandons any access in flight.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= S_FETCH;
        end else if (EN) begin
            state <= next_state;
        end
    end

    // Memory watchdog. The counter counts stalled memory cycles in the
    // current state and restarts whenever the state changes. It freezes
    // with the FSM during a stall.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wait_cnt <= '0;
        end else if (EN) begin
            if (next_state != state) begin
                wait_cnt <= '0;
            end else if (mem_wait && WD_ON) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
        end
    end

    // Next-state logic. mem_wait marks a cycle spent in a memory state
    // without MemReady. Only those cycles can time out, so a MemReady
    // arriving on the expiry cycle still completes the access.
    always_comb begin
        next_state = state;
        mem_wait   = 1'b0;
        case (state)
            S_FETCH: begin
                mem_wait = !MemReady;
                if (MemReady) next_state = S_DECODE;
            end
            S_DECODE: begin
                case (OP)
                    OP_LOAD, OP_STORE: next_state = S_MEMADR;
                    OP_R:              next_state = alu_f3_legal ? S_EXECR : S_TRAP;
                    OP_I:              next_state = alu_f3_legal ? S_EXECI : S_TRAP;
                    OP_BRANCH:         next_state = branch_legal ? S_BRANCH : S_TRAP;
                    OP_JAL:            next_state = S_JAL;
                    default:           next_state = S_TRAP;
                endcase
            end
            S_MEMADR:   next_state = (OP == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD: begin
                mem_wait = !MemReady;
                if (MemReady) next_state = S_MEMWB;
            end
            S_MEMWB:    next_state = S_FETCH;
            S_MEMWRITE: begin
                mem_wait = !MemReady;
                if (MemReady) next_state = S_FETCH;
            end
            S_EXECR:    next_state = S_ALUWB;
            S_EXECI:    next_state = S_ALUWB;
            S_ALUWB:    next_state = S_FETCH;
            S_BRANCH:   next_state = S_FETCH;
            S_JAL:      next_state = S_ALUWB;
            S_TRAP:     next_state = S_TRAP;
            default:    next_state = S_TRAP;
        endcase
        if (mem_wait && wd_expire) next_state = S_TRAP;
    end

    // Datapath controls. The muxes are Moore outputs of the state. The
    // strobes that depend on a handshake are the FETCH PC/IR writes, which
    // wait for MemReady, and the branch PC write, which waits for the
    // comparison result. EXEC states take their ALU operation from funct3.
    always_comb begin
        pc_write_raw  = 1'b0;
        mem_read_raw  = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        AdrSrc        = 1'b0;
        ResultSrc     = RES_ALUOUT;
        ALUSrcA       = SRCA_PC;
        ALUSrcB       = SRCB_REG;
        alu_op        = ALU_ADD;
        case (state)
            S_FETCH: begin
                mem_read_raw = 1'b1;
                ir_write_raw = MemReady;
                pc_write_raw = MemReady;
                ALUSrcA      = SRCA_PC;
                ALUSrcB      = SRCB_FOUR;
                ResultSrc    = RES_ALURES;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_REG;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD: begin
                mem_read_raw = 1'b1;
                AdrSrc       = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc     = RES_DATA;
                reg_write_raw = 1'b1;
            end
            S_MEMWRITE: begin
                mem_write_raw = 1'b1;
                AdrSrc        = 1'b1;
            end
            S_EXECR, S_EXECI: begin
                ALUSrcA = SRCA_REG;
                ALUSrcB = (state == S_EXECR) ? SRCB_REG : SRCB_IMM;
                case (funct3)
                    3'b000:  alu_op = ((state == S_EXECR) && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_op = ALU_SLT;
                    3'b110:  alu_op = ALU_OR;
                    3'b111:  alu_op = ALU_AND;
                    default: alu_op = ALU_ADD;
                endcase
            end
            S_ALUWB: begin
                ResultSrc     = RES_ALUOUT;
                reg_write_raw = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA      = SRCA_REG;
                ALUSrcB      = SRCB_REG;
                alu_op       = ALU_SUB;
                ResultSrc    = RES_ALUOUT;
                pc_write_raw = branch_taken;
            end
            S_JAL: begin
                ALUSrcA      = SRCA_OLDPC;
                ALUSrcB      = SRCB_FOUR;
                ResultSrc    = RES_ALUOUT;
                pc_write_raw = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign PCWrite    = pc_write_raw & enable_ok;
    assign MemRead    = mem_read_raw & enable_ok;
    assign MemWrite   = mem_write_raw & enable_ok;
    assign IRWrite    = ir_write_raw & enable_ok;
    assign RegWrite   = reg_write_raw & enable_ok;
    assign ALUControl = ALU_CTRL_W'(alu_op);
    assign Trap       = (state == S_TRAP);

endmodule

// File: tb/tb_multicycle_control_unit.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control_unit
//
// Directed test for multicycle_control_unit. The main instance uses a 4-bit
// ALUControl and the default 16-cycle watchdog. A second instance has the
// watchdog disabled and shares the same inputs. For every cycle, the
// expected control pattern (value + care mask) is queued when the inputs
// are driven. It is popped and compared on the falling edge.
// ---------------------------------------------------------------------------
module tb_multicycle_control_unit;

    localparam int W = 4;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // bit positions in the packed observation vector
    localparam int PCW = 18, ADR = 17, MRD = 16, MWR = 15, IRW = 14, RGW = 13;
    localparam int RES = 11, SRA = 9, SRB = 7, IMM = 5, ALU = 1, TRP = 0;

    typedef struct packed {
        logic [18:0] val;
        logic [18:0] msk;
    } pat_t;

    typedef struct {
        string tag;
        pat_t  p;
        pat_t  q;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         en;
    logic [6:0]   op;
    logic [2:0]   f3;
    logic         f7;
    logic         zero;
    logic         mem_ready;

    logic         pc_write, adr_src, mem_read, mem_write, ir_write, reg_write, trap;
    logic [1:0]   result_src, alu_src_a, alu_src_b, imm_src;
    logic [W-1:0] alu_control;

    logic         off_pc_write, off_adr_src, off_mem_read, off_mem_write;
    logic         off_ir_write, off_reg_write, off_trap;
    logic [1:0]   off_result_src, off_alu_src_a, off_alu_src_b, off_imm_src;
    logic [W-1:0] off_alu_control;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    multicycle_control_unit #(.ALU_CTRL_W(W), .MEM_TIMEOUT(16)) dut (
        .CLK(clk), .RESET(reset), .EN(en), .OP(op), .funct3(f3), .funct7b5(f7),
        .Zero(zero), .MemReady(mem_ready),
        .PCWrite(pc_write), .AdrSrc(adr_src), .MemRead(mem_read), .MemWrite(mem_write),
        .IRWrite(ir_write), .RegWrite(reg_write), .ResultSrc(result_src),
        .ALUSrcA(alu_src_a), .ALUSrcB(alu_src_b), .ImmSrc(imm_src),
        .ALUControl(alu_control), .Trap(trap)
    );

    multicycle_control_unit #(.ALU_CTRL_W(W), .MEM_TIMEOUT(0)) dut_off (
        .CLK(clk), .RESET(reset), .EN(en), .OP(op), .funct3(f3), .funct7b5(f7),
        .Zero(zero), .MemReady(mem_ready),
        .PCWrite(off_pc_write), .AdrSrc(off_adr_src), .MemRead(off_mem_read),
        .MemWrite(off_mem_write), .IRWrite(off_ir_write), .RegWrite(off_reg_write),
        .ResultSrc(off_result_src), .ALUSrcA(off_alu_src_a), .ALUSrcB(off_alu_src_b),
        .ImmSrc(off_imm_src), .ALUControl(off_alu_control), .Trap(off_trap)
    );

    // ---------------- expectation builders (reference model) ----------------
    function automatic pat_t setf(pat_t p, int lsb, int w, logic [3:0] v);
        for (int i = 0; i < w; i++) begin
            p.val[lsb+i] = v[i];
            p.msk[lsb+i] = 1'b1;
        end
        return p;
    endfunction

    function automatic logic [1:0] imm_of(logic [6:0] o);
        case (o)
            OP_STORE:  return 2'b01;
            OP_BRANCH: return 2'b10;
            OP_JAL:    return 2'b11;
            default:   return 2'b00;
        endcase
    endfunction

    // all enables 0, Trap 0, ImmSrc decoded from the current OP
    function automatic pat_t e_base();
        pat_t p;
        p = '0;
        p = setf(p, PCW, 1, 4'd0);
        p = setf(p, MRD, 1, 4'd0);
        p = setf(p, MWR, 1, 4'd0);
        p = setf(p, IRW, 1, 4'd0);
        p = setf(p, RGW, 1, 4'd0);
        p = setf(p, TRP, 1, 4'd0);
        p = setf(p, IMM, 2, {2'b00, imm_of(op)});
        return p;
    endfunction

    function automatic pat_t e_fetch(logic rdy, logic e);
        pat_t p = e_base();
        p = setf(p, MRD, 1, {3'b0, e});
        p = setf(p, PCW, 1, {3'b0, rdy & e});
        p = setf(p, IRW, 1, {3'b0, rdy & e});
        p = setf(p, ADR, 1, 4'd0);
        p = setf(p, SRA, 2, 4'd0);
        p = setf(p, SRB, 2, 4'd2);
        p = setf(p, ALU, 4, 4'd0);
        p = setf(p, RES, 2, 4'd2);
        return p;
    endfunction

    function automatic pat_t e_decode();
        pat_t p = e_base();
        p = setf(p, SRA, 2, 4'd1);
        p = setf(p, SRB, 2, 4'd1);
        p = setf(p, ALU, 4, 4'd0);
        return p;
    endfunction

    function automatic pat_t e_memadr();
        pat_t p = e_base();
        p = setf(p, SRA, 2, 4'd2);
        p = setf(p, SRB, 2, 4'd1);
        p = setf(p, ALU, 4, 4'd0);
        return p;
    endfunction

    function automatic pat_t e_memread(logic e);
        pat_t p = e_base();
        p = setf(p, MRD, 1, {3'b0, e});
        p = setf(p, ADR, 1, 4'd1);
        return p;
    endfunction

    function automatic pat_t e_memwb(logic e);
        pat_t p = e_base();
        p = setf(p, RES, 2, 4'd1);
        p = setf(p, RGW, 1, {3'b0, e});
        return p;
    endfunction

    function automatic pat_t e_memwrite(logic e);
        pat_t p = e_base();
        p = setf(p, MWR, 1, {3'b0, e});
        p = setf(p, ADR, 1, 4'd1);
        return p;
    endfunction

    function automatic pat_t e_exec(logic is_r);
        pat_t p = e_base();
        logic [3:0] a;
        case (f3)
            3'b000:  a = (is_r && f7) ? 4'd1 : 4'd0;
            3'b010:  a = 4'd5;
            3'b110:  a = 4'd3;
            3'b111:  a = 4'd2;
            default: a = 4'hF;
        endcase
        p = setf(p, SRA, 2, 4'd2);
        p = setf(p, SRB, 2, is_r ? 4'd0 : 4'd1);
        p = setf(p, ALU, 4, a);
        return p;
    endfunction

    function automatic pat_t e_aluwb(logic e);
        pat_t p = e_base();
        p = setf(p, RES, 2, 4'd0);
        p = setf(p, RGW, 1, {3'b0, e});
        return p;
    endfunction

    function automatic pat_t e_branch(logic pcw);
        pat_t p = e_base();
        p = setf(p, SRA, 2, 4'd2);
        p = setf(p, SRB, 2, 4'd0);
        p = setf(p, ALU, 4, 4'd1);
        p = setf(p, RES, 2, 4'd0);
        p = setf(p, PCW, 1, {3'b0, pcw});
        return p;
    endfunction

    function automatic pat_t e_jal(logic e);
        pat_t p = e_base();
        p = setf(p, SRA, 2, 4'd1);
        p = setf(p, SRB, 2, 4'd2);
        p = setf(p, ALU, 4, 4'd0);
        p = setf(p, RES, 2, 4'd0);
        p = setf(p, PCW, 1, {3'b0, e});
        return p;
    endfunction

    function automatic pat_t e_trap();
        pat_t p = e_base();
        p = setf(p, TRP, 1, 4'd1);
        return p;
    endfunction

    // ---------------- stimulus / checking tasks ----------------
    task automatic applyStimulus(input logic e, input logic r, input logic z);
        en        = e;
        mem_ready = r;
        zero      = z;
    endtask

    task automatic setInstr(input logic [6:0] o, input logic [2:0] f, input logic s);
        op = o;
        f3 = f;
        f7 = s;
    endtask

    task automatic push(input string tag, input pat_t p, input pat_t q);
        exp_t x;
        x.tag = tag;
        x.p   = p;
        x.q   = q;
        sb.push_back(x);
    endtask

    task automatic checkOutput();
        exp_t        e;
        logic [18:0] obs;
        logic [18:0] obs0;
        if (sb.size() == 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_empty observed=none expected=entry");
            return;
        end
        e    = sb.pop_front();
        obs  = {pc_write, adr_src, mem_read, mem_write, ir_write, reg_write,
                result_src, alu_src_a, alu_src_b, imm_src, alu_control, trap};
        obs0 = {off_pc_write, off_adr_src, off_mem_read, off_mem_write, off_ir_write,
                off_reg_write, off_result_src, off_alu_src_a, off_alu_src_b,
                off_imm_src, off_alu_control, off_trap};
        checks++;
        assert ((obs & e.p.msk) === (e.p.val & e.p.msk)) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h mask=%h",
                   e.tag, obs & e.p.msk, e.p.val & e.p.msk, e.p.msk);
        end
        if (e.q.msk != '0) begin
            checks++;
            assert ((obs0 & e.q.msk) === (e.q.val & e.q.msk)) else begin
                failures++;
                $error("[TB] FAIL %s_wdoff observed=%h expected=%h mask=%h",
                       e.tag, obs0 & e.q.msk, e.q.val & e.q.msk, e.q.msk);
            end
        end
    endtask

    task automatic step2(input string tag, input logic e, input logic r, input logic z,
                         input pat_t p, input pat_t q);
        applyStimulus(e, r, z);
        push(tag, p, q);
        @(negedge clk);
        checkOutput();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string tag, input logic e, input logic r, input logic z,
                        input pat_t p);
        step2(tag, e, r, z, p, '0);
    endtask

    task automatic applyReset();
        reset = 1'b0;
        step("reset", 1'b1, 1'b1, 1'b0, e_base());
        reset = 1'b1;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

    initial begin
        reset = 1'b0;
        setInstr(OP_R, 3'b000, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        step("reset_hold", 1'b1, 1'b1, 1'b0, e_base());
        reset = 1'b1;

        // add x3,x1,x2 : FETCH, DECODE, EXECR, ALUWB
        setInstr(OP_R, 3'b000, 1'b0);
        step("add_fetch",  1, 1, 0, e_fetch(1, 1));
        step("add_decode", 1, 1, 0, e_decode());
        step("add_execr",  1, 1, 0, e_exec(1));
        step("add_aluwb",  1, 1, 0, e_aluwb(1));

        // sub and slt
        setInstr(OP_R, 3'b000, 1'b1);
        step("sub_fetch",  1, 1, 0, e_fetch(1, 1));
        step("sub_decode", 1, 1, 0, e_decode());
        step("sub_execr",  1, 1, 0, e_exec(1));
        step("sub_aluwb",  1, 1, 0, e_aluwb(1));
        setInstr(OP_R, 3'b010, 1'b0);
        step("slt_fetch",  1, 1, 0, e_fetch(1, 1));
        step("slt_decode", 1, 1, 0, e_decode());
        step("slt_execr",  1, 1, 0, e_exec(1));
        step("slt_aluwb",  1, 1, 0, e_aluwb(1));

        // lw with three wait cycles in MEMREAD
        setInstr(OP_LOAD, 3'b010, 1'b0);
        step("lw_fetch",  1, 1, 0, e_fetch(1, 1));
        step("lw_decode", 1, 1, 0, e_decode());
        step("lw_memadr", 1, 1, 0, e_memadr());
        for (int i = 0; i < 3; i++) step("lw_memread_wait", 1, 0, 0, e_memread(1));
        step("lw_memread_done", 1, 1, 0, e_memread(1));
        step("lw_memwb",  1, 1, 0, e_memwb(1));

        // sw with zero waits
        setInstr(OP_STORE, 3'b010, 1'b0);
        step("sw_fetch",    1, 1, 0, e_fetch(1, 1));
        step("sw_decode",   1, 1, 0, e_decode());
        step("sw_memadr",   1, 1, 0, e_memadr());
        step("sw_memwrite", 1, 1, 0, e_memwrite(1));

        // beq taken, then not taken
        setInstr(OP_BRANCH, 3'b000, 1'b0);
        step("beq_t_fetch",  1, 1, 0, e_fetch(1, 1));
        step("beq_t_decode", 1, 1, 0, e_decode());
        step("beq_t_branch", 1, 1, 1, e_branch(1));
        step("beq_n_fetch",  1, 1, 0, e_fetch(1, 1));
        step("beq_n_decode", 1, 1, 0, e_decode());
        step("beq_n_branch", 1, 1, 0, e_branch(0));

        // jal
        setInstr(OP_JAL, 3'b000, 1'b0);
        step("jal_fetch",  1, 1, 0, e_fetch(1, 1));
        step("jal_decode", 1, 1, 0, e_decode());
        step("jal_jal",    1, 1, 0, e_jal(1));
        step("jal_aluwb",  1, 1, 0, e_aluwb(1));

        // ori with a five-cycle stall in EXECI
        setInstr(OP_I, 3'b110, 1'b1);
        step("ori_fetch",  1, 1, 0, e_fetch(1, 1));
        step("ori_decode", 1, 1, 0, e_decode());
        for (int i = 0; i < 5; i++) step("ori_stall", 0, 1, 0, e_exec(0));
        step("ori_execi",  1, 1, 0, e_exec(0));
        step("ori_aluwb",  1, 1, 0, e_aluwb(1));

        // and: a FETCH stall ignores MemReady
        setInstr(OP_R, 3'b111, 1'b0);
        step("and_fetch_stall", 0, 1, 0, e_fetch(1, 0));
        step("and_fetch",       1, 1, 0, e_fetch(1, 1));
        step("and_decode",      1, 1, 0, e_decode());
        step("and_execr",       1, 1, 0, e_exec(1));
        step("and_aluwb",       1, 1, 0, e_aluwb(1));

        // lw: frozen watchdog, ready on the expiry cycle, counter restarts per state
        setInstr(OP_LOAD, 3'b010, 1'b0);
        for (int i = 0; i < 10; i++) step("lw2_fetch_wait", 1, 0, 0, e_fetch(0, 1));
        for (int i = 0; i < 8; i++)  step("lw2_fetch_stall", 0, 0, 0, e_fetch(0, 0));
        for (int i = 0; i < 5; i++)  step("lw2_fetch_wait2", 1, 0, 0, e_fetch(0, 1));
        step("lw2_fetch_expiry_ready", 1, 1, 0, e_fetch(1, 1));
        step("lw2_decode", 1, 1, 0, e_decode());
        step("lw2_memadr", 1, 1, 0, e_memadr());
        for (int i = 0; i < 12; i++) step("lw2_memread_wait", 1, 0, 0, e_memread(1));
        step("lw2_memread_done", 1, 1, 0, e_memread(1));
        step("lw2_memwb", 1, 1, 0, e_memwb(1));

        // bne: legal only with the branch extension
        setInstr(OP_BRANCH, 3'b001, 1'b0);
        step("bne_fetch",  1, 1, 0, e_fetch(1, 1));
        step("bne_decode", 1, 1, 0, e_decode());
`ifdef MCCU_BRANCH_EXT_EN
        step("bne_branch", 1, 1, 0, e_branch(1));
        step("bne_next_fetch", 1, 1, 1, e_fetch(1, 1));
`else
        step("bne_trap",   1, 1, 0, e_trap());
        step("bne_trap_hold", 1, 1, 0, e_trap());
`endif
        applyReset();

        // R-type with illegal funct3 (sll)
        setInstr(OP_R, 3'b001, 1'b0);
        step("sll_fetch",  1, 1, 0, e_fetch(1, 1));
        step("sll_decode", 1, 1, 0, e_decode());
        step("sll_trap",   1, 1, 0, e_trap());
        applyReset();

        // unsupported opcode (ecall): sticky trap
        setInstr(OP_SYSTEM, 3'b000, 1'b0);
        step("sys_fetch",  1, 1, 0, e_fetch(1, 1));
        step("sys_decode", 1, 1, 0, e_decode());
        for (int i = 0; i < 3; i++) step("sys_trap", 1, 1, 0, e_trap());
        applyReset();
        step("post_trap_fetch", 1, 0, 0, e_fetch(0, 1));

        // reset in the middle of a store drops MemWrite immediately
        applyReset();
        setInstr(OP_STORE, 3'b010, 1'b0);
        step("swr_fetch",  1, 1, 0, e_fetch(1, 1));
        step("swr_decode", 1, 1, 0, e_decode());
        step("swr_memadr", 1, 1, 0, e_memadr());
        applyStimulus(1'b1, 1'b0, 1'b0);
        push("swr_memwrite_wait", e_memwrite(1), '0);
        @(negedge clk);
        checkOutput();
        #2;
        reset = 1'b0;
        push("swr_async_abort", e_base(), '0);
        #1;
        checkOutput();
        @(posedge clk);
        #1;
        reset = 1'b1;
        setInstr(OP_R, 3'b000, 1'b0);
        step("swr_refetch", 1, 1, 0, e_fetch(1, 1));

        // watchdog: MemReady stuck low in FETCH
        applyReset();
        for (int i = 0; i < 16; i++)
            step2("wd_fetch_wait", 1, 0, 0, e_fetch(0, 1), e_fetch(0, 1));
        step2("wd_trap", 1, 0, 0, e_trap(), e_fetch(0, 1));
        for (int i = 0; i < 20; i++)
            step2("wd_trap_hold", 1, 0, 0, e_trap(), e_fetch(0, 1));
        applyReset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
